dbus_bridge: RTL

// - Responder end of the CPU data bus: takes addr_out / Bus_wdata / en_data_trans from myCPU, returns data_to_cpu.
// - Decodes address to DRAM or the memory-mapped peripherals: LED, 7-seg, switches, buttons, timer.
// - Owns all peripheral state: registers, timer, 7-seg scan FSM and input synchronisers.
// - Sits between myCPU and board I/O in the SoC top.

---
 rtl/dbus_bridge_pkg.sv | 64 ++++++
 rtl/dbus_bridge_seg7_scan.sv | 52 +++++
 rtl/dbus_bridge.sv | 116 +++++++++++
 3 files changed

// File: rtl/dbus_bridge_pkg.sv
// Shared constants for the CPU data-bus bridge: peripheral offsets, register selects,
// 7-seg scan states and the hex-to-segment table.
package dbus_bridge_pkg;

    localparam logic [31:0] PERI_BASE_DEF = 32'hFFFF_F000;

    localparam logic [11:0] OFF_DIG   = 12'h000;
    localparam logic [11:0] OFF_TIMER = 12'h020;
    localparam logic [11:0] OFF_TDIV  = 12'h024;
    localparam logic [11:0] OFF_LED   = 12'h060;
    localparam logic [11:0] OFF_SW    = 12'h070;
    localparam logic [11:0] OFF_BTN   = 12'h078;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_DIG,
        SEL_TIMER,
        SEL_TDIV,
        SEL_LED,
        SEL_SW,
        SEL_BTN
    } peri_sel_e;

    typedef enum logic [2:0] {
        DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7
    } scan_state_e;

    function automatic peri_sel_e decode_off(input logic [11:0] off);
        case (off)
            OFF_DIG:   return SEL_DIG;
            OFF_TIMER: return SEL_TIMER;
            OFF_TDIV:  return SEL_TDIV;
            OFF_LED:   return SEL_LED;
            OFF_SW:    return SEL_SW;
            OFF_BTN:   return SEL_BTN;
            default:   return SEL_NONE;
        endcase
    endfunction

    // Segment pattern {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 8'hC0;
            4'h1: return 8'hF9;
            4'h2: return 8'hA4;
            4'h3: return 8'hB0;
            4'h4: return 8'h99;
            4'h5: return 8'h92;
            4'h6: return 8'h82;
            4'h7: return 8'hF8;
            4'h8: return 8'h80;
            4'h9: return 8'h90;
            4'hA: return 8'h88;
            4'hB: return 8'h83;
            4'hC: return 8'hC6;
            4'hD: return 8'hA1;
            4'hE: return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

endpackage

// File: rtl/dbus_bridge_seg7_scan.sv
// Eight-digit multiplexed 7-seg driver: steps one digit every SCAN_DIV cycles and
// registers the digit enable and decoded segments one cycle after each step.
module seg7_scan
    import dbus_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_dig_data,
    output logic [7:0]  o_dig_en,
    output logic [7:0]  o_dig_seg
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    scan_state_e      r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_refresh;
    logic             w_term;
    logic [4:0]       w_shift;
    logic [3:0]       w_nib;

    assign w_term  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_shift = {r_idx, 2'b00};
    assign w_nib   = i_dig_data[w_shift +: 4];

    // r_refresh marks the cycle after an index change (and the first cycle out of
    // reset), so the display latches dig_data only at digit boundaries.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx     <= DIG0;
            r_cnt     <= '0;
            r_refresh <= 1'b1;
            o_dig_en  <= 8'hFF;
            o_dig_seg <= SEG_BLANK;
        end else begin
            if (r_refresh) begin
                o_dig_en  <= ~(8'b1 << r_idx);
                o_dig_seg <= hex_to_seg(w_nib);
            end
            r_refresh <= w_term;
            if (w_term) begin
                r_cnt <= '0;
                r_idx <= scan_state_e'(r_idx + 3'd1);
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dbus_bridge.sv
// Responder end of the CPU data bus: DRAM/peripheral decode, single-cycle combinational
// reads, LED/DIG/timer registers, switch/button synchronisers and the 7-seg scanner.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int          DRAM_AW   = 14,
    parameter int          SCAN_DIV  = 20000,
    parameter logic [31:0] PERI_BASE = PERI_BASE_DEF
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic               en_data_trans,
    input  logic [31:0]        addr_out,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        data_to_cpu,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         dig_seg
);

    logic        w_peri;
    logic        w_we;
    logic [11:0] w_off;
    peri_sel_e   w_sel;
    logic        w_tick;

    logic [23:0] r_led;
    logic [31:0] r_dig_data;
    logic [31:0] r_timer;
    logic [31:0] r_tdiv;
    logic [31:0] r_prescale;
    logic [23:0] r_sw1, r_sw2;
    logic [4:0]  r_btn1, r_btn2;

    assign w_peri = (addr_out >= PERI_BASE);
    assign w_off  = addr_out[11:0] - PERI_BASE[11:0];
    assign w_sel  = w_peri ? decode_off(w_off) : SEL_NONE;

    // Stores presented while reset is asserted are dropped, including DRAM stores.
    assign w_we = en_data_trans & ~cpu_rst;

    assign dram_addr  = addr_out[DRAM_AW+1:2];
    assign dram_wdata = Bus_wdata;
    assign dram_we    = w_we & ~w_peri;
    assign led        = r_led;

    always_comb begin
        data_to_cpu = '0;
        if (!w_peri) begin
            data_to_cpu = dram_rdata;
        end else begin
            case (w_sel)
                SEL_TIMER: data_to_cpu = r_timer;
                SEL_TDIV:  data_to_cpu = r_tdiv;
                SEL_LED:   data_to_cpu = {8'h00, r_led};
                SEL_SW:    data_to_cpu = {8'h00, r_sw2};
                SEL_BTN:   data_to_cpu = {27'h0, r_btn2};
                default:   data_to_cpu = '0;
            endcase
        end
    end

    assign w_tick = (r_tdiv != 32'd0) && (r_prescale == r_tdiv - 32'd1);

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_led      <= '0;
            r_dig_data <= '0;
            r_timer    <= '0;
            r_tdiv     <= '0;
            r_prescale <= '0;
            r_sw1      <= '0;
            r_sw2      <= '0;
            r_btn1     <= '0;
            r_btn2     <= '0;
        end else begin
            r_sw1  <= sw;
            r_sw2  <= r_sw1;
            r_btn1 <= btn;
            r_btn2 <= r_btn1;

            if (w_we && w_sel == SEL_LED) r_led      <= Bus_wdata[23:0];
            if (w_we && w_sel == SEL_DIG) r_dig_data <= Bus_wdata;

            if (w_we && w_sel == SEL_TDIV) begin
                r_tdiv     <= Bus_wdata;
                r_prescale <= '0;
            end else if (r_tdiv == 32'd0 || w_tick) begin
                r_prescale <= '0;
            end else begin
                r_prescale <= r_prescale + 32'd1;
            end

            // A software write to TIMER takes precedence over a coincident tick.
            if (w_we && w_sel == SEL_TIMER) r_timer <= Bus_wdata;
            else if (w_tick)                r_timer <= r_timer + 32'd1;
        end
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .i_clk      (cpu_clk),
        .i_rst      (cpu_rst),
        .i_dig_data (r_dig_data),
        .o_dig_en   (dig_en),
        .o_dig_seg  (dig_seg)
    );

endmodule
